// File: rtl/mtr_drv_pkg.sv
// mtr_drv_pkg: shared types, constants and the duty slew helper for the motor driver
// Contents: PWM_PERIOD, SLEW_STEP, drv_state_t, duty_t, slew_to()
package mtr_drv_pkg;
    localparam int PWM_PERIOD = 2048;
    localparam int SLEW_STEP = 64;
    typedef enum logic [1:0] {IDLE, DRIVE, COAST} drv_state_t;
    typedef logic [10:0] duty_t;
    // Move cur toward tgt by at most SLEW_STEP, landing exactly on tgt when close enough
    function automatic duty_t slew_to(input duty_t cur, input duty_t tgt);
        return (tgt > cur) ? ((tgt - cur > duty_t'(SLEW_STEP)) ? cur + duty_t'(SLEW_STEP) : tgt)
                           : ((cur - tgt > duty_t'(SLEW_STEP)) ? cur - duty_t'(SLEW_STEP) : tgt);
    endfunction
endpackage

// File: rtl/mtr_drv_chan.sv
// mtr_chan: one wheel's sign/magnitude PWM channel with reversal coast protection
// Ports: clk, rst_n (async active-low), pwr_up, spd (signed 12b), cnt (shared PWM counter),
//        bnd (high while cnt is at its last count), fwd_pwm / rev_pwm (registered bridge lines)
// Macro: MTR_DRV_SLEW_LIMIT_EN limits duty changes to SLEW_STEP per period
module mtr_chan
    import mtr_drv_pkg::*;
#(
    parameter int PWM_BITS = 11,
    parameter int COAST_PERIODS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwr_up,
    input  logic [11:0]         spd,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                bnd,
    output logic                fwd_pwm,
    output logic                rev_pwm
);
`ifdef MTR_DRV_SLEW_LIMIT_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif
    drv_state_t st, st_n;
    logic       dir, dir_n;
    duty_t      duty, duty_n;
    logic [1:0] ccnt, ccnt_n;
    logic       s_dir;
    duty_t      s_mag;
    function automatic duty_t ramp(input duty_t cur, input duty_t tgt);
        return SLEW ? slew_to(cur, tgt) : tgt;
    endfunction
    assign s_dir = spd[11];
    // -2048 is the only negative value with zero low bits; it saturates to full scale
    assign s_mag = !s_dir ? spd[10:0] : (spd[10:0] == '0) ? '1 : ~spd[10:0] + 11'd1;
    always_comb begin
        st_n   = st;
        dir_n  = dir;
        duty_n = duty;
        ccnt_n = ccnt;
        if (!pwr_up) begin
            st_n   = IDLE;
            duty_n = '0;
        end else if (bnd) begin
            case (st)
                DRIVE: begin
                    // A live reversal ramps down (when slewing) and then coasts before the flip
                    if (s_dir != dir && duty != '0) begin
                        if (SLEW && duty > duty_t'(SLEW_STEP)) duty_n = duty - duty_t'(SLEW_STEP);
                        else begin
                            st_n   = COAST;
                            ccnt_n = 2'(COAST_PERIODS);
                            duty_n = '0;
                        end
                    end else begin
                        dir_n  = s_dir;
                        duty_n = ramp(duty, s_mag);
                    end
                end
                COAST: begin
                    ccnt_n = ccnt - 2'd1;
                    if (ccnt == 2'd1) begin
                        st_n   = DRIVE;
                        dir_n  = s_dir;
                        duty_n = ramp('0, s_mag);
                    end
                end
                default: begin
                    st_n   = DRIVE;
                    dir_n  = s_dir;
                    duty_n = ramp('0, s_mag);
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            dir     <= 1'b0;
            duty    <= '0;
            ccnt    <= '0;
            fwd_pwm <= 1'b0;
            rev_pwm <= 1'b0;
        end else begin
            st      <= st_n;
            dir     <= dir_n;
            duty    <= duty_n;
            ccnt    <= ccnt_n;
            fwd_pwm <= pwr_up && st == DRIVE && !dir && cnt < duty;
            rev_pwm <= pwr_up && st == DRIVE && dir && cnt < duty;
        end
    end
endmodule

// File: rtl/mtr_drv.sv
// mtr_drv: dual-wheel H-bridge PWM driver with shared period counter
// Ports: clk, rst_n (async active-low), pwr_up, lft_spd / rght_spd (signed 12b),
//        lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, prd_done (pulse after each wrap)
// Macro: MTR_DRV_SLEW_LIMIT_EN enables per-period duty slew limiting in both channels
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter int PWM_BITS = 11,
    parameter int COAST_PERIODS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_up,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    output logic        lft_fwd_pwm,
    output logic        lft_rev_pwm,
    output logic        rght_fwd_pwm,
    output logic        rght_rev_pwm,
    output logic        prd_done
);
    logic [PWM_BITS-1:0] cnt;
    logic                bnd;
    assign bnd = cnt == PWM_BITS'(PWM_PERIOD - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            prd_done <= 1'b0;
        end else begin
            cnt      <= cnt + 1'b1;
            prd_done <= bnd;
        end
    end
    mtr_chan #(.PWM_BITS(PWM_BITS), .COAST_PERIODS(COAST_PERIODS)) u_lft (
        .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .spd(lft_spd), .cnt(cnt), .bnd(bnd),
        .fwd_pwm(lft_fwd_pwm), .rev_pwm(lft_rev_pwm)
    );
    mtr_chan #(.PWM_BITS(PWM_BITS), .COAST_PERIODS(COAST_PERIODS)) u_rght (
        .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .spd(rght_spd), .cnt(cnt), .bnd(bnd),
        .fwd_pwm(rght_fwd_pwm), .rev_pwm(rght_rev_pwm)
    );
endmodule
